lutreg_reduce_pipe: RTL

Parametrised, pipelined reduction block for CLB LUT-register-LUT benchmarking: registers a WIDTH-bit input vector, reduces it through a tree of LUT_K-input groups with a register after every tree level, and delivers a 1-bit result with a valid flag. Per-transaction reduction operator, global clock enable, and valid tracking generalise the fixed 8-input AND pipeline. Sits between benchmark I/O pads and the result capture logic in CLB timing/packing test designs.

---
 rtl/lutreg_reduce_pipe.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/lutreg_reduce_pipe.sv
// lutreg_reduce_pipe: registers a WIDTH-bit vector, reduces it through a LUT_K-ary tree with a register per level.
// Latency: LEVELS+1 enabled clocks from in_valid sample to out_valid; one transaction per enabled clock.
// Backpressure: none; ce=0 freezes every register. Optional LUTREG_REDUCE_CNT_EN adds ones_cnt/cnt_clr.
module lutreg_reduce_pipe #(
  parameter int WIDTH = 8,
  parameter int LUT_K = 6
) (
  input  logic             clock0,
  input  logic             reset,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  output logic             out_data
`ifdef LUTREG_REDUCE_CNT_EN
  ,
  output logic [15:0]      ones_cnt,
  input  logic             cnt_clr
`endif
);

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  // Smallest L with k^L >= w.
  function automatic int calc_levels(int w, int k);
    int l;
    int p;
    l = 0;
    p = 1;
    while (p < w) begin
      p = p * k;
      l = l + 1;
    end
    return l;
  endfunction

  // Width of tree level n (level 0 is the registered input vector).
  function automatic int lvl_w(int n);
    int w;
    w = WIDTH;
    for (int i = 0; i < n; i++) w = (w + LUT_K - 1) / LUT_K;
    return w;
  endfunction

  // Bit offset of level n inside the flattened data pipeline.
  function automatic int lvl_off(int n);
    int o;
    o = 0;
    for (int i = 0; i < n; i++) o = o + lvl_w(i);
    return o;
  endfunction

  localparam int LEVELS = calc_levels(WIDTH, LUT_K);
  localparam int TOTAL  = lvl_off(LEVELS + 1);

  // All level registers packed back to back; the last level is the single out_data bit.
  logic [TOTAL-1:0] dat_q;
  logic [TOTAL-1:0] dat_d;
  logic [1:0]       op_q [0:LEVELS-1];
  logic [LEVELS:0]  vld_q;

  assign dat_d[WIDTH-1:0] = in_data;

  for (genvar n = 1; n <= LEVELS; n++) begin : g_lvl
    localparam int WI = lvl_w(n - 1);
    localparam int WO = lvl_w(n);
    localparam int OI = lvl_off(n - 1);
    localparam int OO = lvl_off(n);

    logic [1:0]          op;
    logic [WO*LUT_K-1:0] padded;
    logic [WO-1:0]       red;

    assign op = op_q[n-1];

    // Partial last group is filled with the operator identity so it never alters the result.
    for (genvar i = 0; i < WO * LUT_K; i++) begin : g_pad
      if (i < WI) begin : g_src
        assign padded[i] = dat_q[OI+i];
      end else begin : g_id
        assign padded[i] = (op == OP_AND) || (op == OP_NAND);
      end
    end

    // NAND travels as AND through the tree.
    for (genvar g = 0; g < WO; g++) begin : g_grp
      logic [LUT_K-1:0] grp;
      assign grp    = padded[g*LUT_K +: LUT_K];
      assign red[g] = (op == OP_OR)  ? |grp :
                      (op == OP_XOR) ? ^grp : &grp;
    end

    if (n == LEVELS) begin : g_last
      // The only inversion for NAND, right before the out_data register.
      assign dat_d[OO] = red[0] ^ (op == OP_NAND);
    end else begin : g_mid
      assign dat_d[OO +: WO] = red;
    end
  end

  // Whole pipeline (data, op, valid) advances together on ce; reset discards everything in flight.
  always_ff @(posedge clock0 or posedge reset) begin
    if (reset) begin
      dat_q <= '0;
      vld_q <= '0;
      for (int n = 0; n < LEVELS; n++) op_q[n] <= 2'b00;
    end else if (ce) begin
      dat_q    <= dat_d;
      vld_q    <= {vld_q[LEVELS-1:0], in_valid};
      op_q[0]  <= in_op;
      for (int n = 1; n < LEVELS; n++) op_q[n] <= op_q[n-1];
    end
  end

  assign out_valid = vld_q[LEVELS];
  assign out_data  = dat_q[TOTAL-1];

`ifdef LUTREG_REDUCE_CNT_EN
  logic final_one;
  assign final_one = vld_q[LEVELS-1] & dat_d[TOTAL-1];

  // Counts results of 1 as they are loaded into the output register; clear wins, saturates at all-ones.
  always_ff @(posedge clock0 or posedge reset) begin
    if (reset) begin
      ones_cnt <= '0;
    end else if (ce) begin
      if (cnt_clr) begin
        ones_cnt <= '0;
      end else if (final_one && (ones_cnt != 16'hFFFF)) begin
        ones_cnt <= ones_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
